icache_direct: RTL and testbench

- Direct-mapped instruction cache between the instruction fetcher (upstream) and the memory controller (downstream).
- Hits return a 32-bit instruction one cycle after the request.
- On a miss, a single word fetch is issued to the memory controller over its fet_ena/instr_addr/valid handshake, the line is filled, and the instruction is forwarded.
- A flush (clr) on misprediction cancels delivery but never aborts an in-flight memory fetch.

---
 rtl/icache_direct_pkg.sv | 14 +
 rtl/icache_direct_array.sv | 49 ++++
 rtl/icache_direct.sv | 156 +++++++++++++++
 tb/tb_icache_direct.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/icache_direct_pkg.sv
// Shared constants and state encoding for the direct-mapped instruction cache.
package icache_direct_pkg;

    localparam int ICACHE_INDEX_BITS = 8;
    localparam int ICACHE_ADDR_W     = 32;
    localparam int ICACHE_WORD_W     = 32;

    typedef enum logic [1:0] {
        ICACHE_IDLE  = 2'd0,
        ICACHE_MISS  = 2'd1,
        ICACHE_DRAIN = 2'd2
    } icache_state_e;

endpackage

// File: rtl/icache_direct_array.sv
// Valid/tag/data storage for icache_direct: combinational lookup, single write port.
module icache_array
    import icache_direct_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int TAG_W      = ICACHE_ADDR_W - ICACHE_INDEX_BITS - 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INDEX_BITS-1:0]    rd_idx,
    input  logic [TAG_W-1:0]         rd_tag,
    output logic                     hit,
    output logic [ICACHE_WORD_W-1:0] rd_word,
    input  logic                     we,
    input  logic [INDEX_BITS-1:0]    wr_idx,
    input  logic [TAG_W-1:0]         wr_tag,
    input  logic [ICACHE_WORD_W-1:0] wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic                     valid_reg [LINES];
    logic [TAG_W-1:0]         tag_reg   [LINES];
    logic [ICACHE_WORD_W-1:0] data_reg  [LINES];

    // Only the valid bits need reset; tag/data stay plain RAM.
    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_valid
            always_ff @(posedge clk) begin
                if (rst)
                    valid_reg[gi] <= 1'b0;
                else if (we && (wr_idx == INDEX_BITS'(gi)))
                    valid_reg[gi] <= 1'b1;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (we) begin
            tag_reg[wr_idx]  <= wr_tag;
            data_reg[wr_idx] <= wr_data;
        end
    end

    assign hit     = valid_reg[rd_idx] && (tag_reg[rd_idx] == rd_tag);
    assign rd_word = data_reg[rd_idx];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache with single-word miss fill and flush-aware drain.
// Optional hit/miss counters are built when ICACHE_STAT_EN is defined.
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int ADDR_W     = ICACHE_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic              fet_ena,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic              mc_valid,
    input  logic [31:0]       mc_data
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

    icache_state_e           state_reg, state_next;
    logic                    instr_valid_reg, instr_valid_next;
    logic [31:0]             instr_reg, instr_next;
    logic                    fet_ena_reg, fet_ena_next;
    logic [ADDR_W-1:0]       instr_addr_reg, instr_addr_next;
    logic [INDEX_BITS-1:0]   miss_idx_reg, miss_idx_next;
    logic [TAG_W-1:0]        miss_tag_reg, miss_tag_next;

    logic [INDEX_BITS-1:0]   pc_idx;
    logic [TAG_W-1:0]        pc_tag;
    logic                    hit;
    logic [31:0]             rd_word;
    logic                    accept;
    logic                    fill_we;

    assign pc_idx = fetch_pc[INDEX_BITS+1:2];
    assign pc_tag = fetch_pc[ADDR_W-1:INDEX_BITS+2];

    // Blocking on instr_valid_reg gives the bubble that stops a held request being served twice.
    assign accept  = (state_reg == ICACHE_IDLE) && fetch_req && !instr_valid_reg && !clr;
    assign fill_we = rdy && (state_reg != ICACHE_IDLE) && mc_valid;

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (pc_idx),
        .rd_tag  (pc_tag),
        .hit     (hit),
        .rd_word (rd_word),
        .we      (fill_we),
        .wr_idx  (miss_idx_reg),
        .wr_tag  (miss_tag_reg),
        .wr_data (mc_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ICACHE_IDLE;
            instr_valid_reg <= 1'b0;
            instr_reg       <= '0;
            fet_ena_reg     <= 1'b0;
            instr_addr_reg  <= '0;
            miss_idx_reg    <= '0;
            miss_tag_reg    <= '0;
        end else if (rdy) begin
            state_reg       <= state_next;
            instr_valid_reg <= instr_valid_next;
            instr_reg       <= instr_next;
            fet_ena_reg     <= fet_ena_next;
            instr_addr_reg  <= instr_addr_next;
            miss_idx_reg    <= miss_idx_next;
            miss_tag_reg    <= miss_tag_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ICACHE_IDLE:  if (accept && !hit) state_next = ICACHE_MISS;
            ICACHE_MISS: begin
                if (mc_valid)  state_next = ICACHE_IDLE;
                else if (clr)  state_next = ICACHE_DRAIN;
            end
            ICACHE_DRAIN: if (mc_valid) state_next = ICACHE_IDLE;
            default:      state_next = ICACHE_IDLE;
        endcase
    end

    always_comb begin
        instr_valid_next = 1'b0;
        instr_next       = instr_reg;
        fet_ena_next     = fet_ena_reg;
        instr_addr_next  = instr_addr_reg;
        miss_idx_next    = miss_idx_reg;
        miss_tag_next    = miss_tag_reg;
        case (state_reg)
            ICACHE_IDLE: begin
                if (accept && hit) begin
                    instr_valid_next = 1'b1;
                    instr_next       = rd_word;
                end else if (accept) begin
                    fet_ena_next    = 1'b1;
                    instr_addr_next = fetch_pc;
                    miss_idx_next   = pc_idx;
                    miss_tag_next   = pc_tag;
                end
            end
            ICACHE_MISS: begin
                if (mc_valid) begin
                    fet_ena_next = 1'b0;
                    if (!clr) begin
                        instr_valid_next = 1'b1;
                        instr_next       = mc_data;
                    end
                end
            end
            ICACHE_DRAIN: if (mc_valid) fet_ena_next = 1'b0;
            default:      fet_ena_next = 1'b0;
        endcase
    end

    assign instr_valid = instr_valid_reg;
    assign instr       = instr_reg;
    assign fet_ena     = fet_ena_reg;
    assign instr_addr  = instr_addr_reg;

`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt_reg, miss_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else if (rdy && accept) begin
            if (hit) hit_cnt_reg  <= hit_cnt_reg + 32'd1;
            else     miss_cnt_reg <= miss_cnt_reg + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_reg;
    assign miss_cnt = miss_cnt_reg;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: expected responses are queued by the stimulus, a monitor pops them.
module tb_icache_direct;

    logic        clk = 1'b0;
    logic        rst, rdy, clr, fetch_req, mc_valid;
    logic [31:0] fetch_pc, mc_data;
    logic        instr_valid, fet_ena;
    logic [31:0] instr, instr_addr;
`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int errors = 0, checks = 0;
    int mon_errors = 0, mon_checks = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    icache_direct dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .clr         (clr),
        .fetch_req   (fetch_req),
        .fetch_pc    (fetch_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .fet_ena     (fet_ena),
        .instr_addr  (instr_addr),
        .mc_valid    (mc_valid),
        .mc_data     (mc_data)
`ifdef ICACHE_STAT_EN
        ,
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
`endif
    );

    // Monitor: every instr_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && instr_valid) begin
            mon_checks++;
            if (exp_q.size() == 0) begin
                mon_errors++;
                $display("FAIL resp_unexpected: got instr_valid with instr=%08h, required no response", instr);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (instr !== e) begin
                    mon_errors++;
                    $display("FAIL resp_data: got %08h, required %08h", instr, e);
                end else
                    $display("resp ok: instr=%08h", instr);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h, required %08h", name, act, req);
        end else
            $display("check %s ok: %08h", name, act);
    endtask

    // One-cycle request; pushes the expectation when a hit is anticipated.
    task automatic req(input logic [31:0] pc, input bit exp_hit, input logic [31:0] exp_data);
        fetch_req = 1'b1;
        fetch_pc  = pc;
        if (exp_hit) exp_q.push_back(exp_data);
        step();
        fetch_req = 1'b0;
        if (exp_hit) chk("hit_no_fetch", {31'd0, fet_ena}, 32'd0);
        else begin
            chk("miss_fet_ena", {31'd0, fet_ena}, 32'd1);
            chk("miss_addr", instr_addr, pc);
        end
    endtask

    task automatic fill(input int wait_cyc, input logic [31:0] data, input bit owed);
        for (int i = 0; i < wait_cyc; i++) step();
        mc_valid = 1'b1;
        mc_data  = data;
        if (owed) exp_q.push_back(data);
        step();
        mc_valid = 1'b0;
        chk("fill_fet_drop", {31'd0, fet_ena}, 32'd0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; clr = 1'b0; fetch_req = 1'b0; mc_valid = 1'b0;
        fetch_pc = '0; mc_data = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_fet_ena", {31'd0, fet_ena}, 32'd0);
        chk("rst_instr_addr", instr_addr, 32'd0);

        // Cold miss, fill after 6 cycles, then a hit.
        req(32'h10, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) step();
        chk("miss_held", {31'd0, fet_ena}, 32'd1);
        fill(0, 32'h00A00093, 1'b1);
        req(32'h10, 1'b1, 32'h00A00093);
        step();

        // Conflict eviction on index 4.
        req(32'h410, 1'b0, 32'h0);
        fill(2, 32'hDEADBEEF, 1'b1);
        req(32'h10, 1'b0, 32'h0);
        fill(1, 32'h00A00093, 1'b1);

        // Flush during miss -> DRAIN, fill lands but no response.
        req(32'h20, 1'b0, 32'h0);
        step();
        clr = 1'b1; step(); clr = 1'b0;
        chk("drain_fet_held", {31'd0, fet_ena}, 32'd1);
        step(); step();
        fill(0, 32'h11111111, 1'b0);
        chk("drain_instr_hold", instr, 32'h00A00093);
        req(32'h20, 1'b1, 32'h11111111);
        step();

        // Flush coincident with mc_valid.
        req(32'h30, 1'b0, 32'h0);
        step();
        clr = 1'b1;
        fill(0, 32'h22222222, 1'b0);
        clr = 1'b0;
        req(32'h30, 1'b1, 32'h22222222);
        step();

        // clr in IDLE blocks a request that would hit.
        fetch_req = 1'b1; fetch_pc = 32'h30; clr = 1'b1;
        step();
        fetch_req = 1'b0; clr = 1'b0;
        chk("clr_idle_no_resp", {31'd0, instr_valid}, 32'd0);
        chk("clr_idle_no_fetch", {31'd0, fet_ena}, 32'd0);
        step();

        // rdy low while mc_valid is presented.
        req(32'h40, 1'b0, 32'h0);
        step();
        rdy = 1'b0; mc_valid = 1'b1; mc_data = 32'h33333333;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frozen_fet_ena", {31'd0, fet_ena}, 32'd1);
            chk("frozen_valid", {31'd0, instr_valid}, 32'd0);
        end
        rdy = 1'b1;
        mc_valid = 1'b0;
        fill(0, 32'h33333333, 1'b1);
        req(32'h40, 1'b1, 32'h33333333);
        step();

        // Reset mid-miss abandons the fill.
        req(32'h50, 1'b0, 32'h0);
        step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_mid_fet_ena", {31'd0, fet_ena}, 32'd0);
        chk("rst_mid_addr", instr_addr, 32'd0);
        req(32'h10, 1'b0, 32'h0);
        fill(1, 32'h44444444, 1'b1);
        req(32'h10, 1'b1, 32'h44444444);
        step(); step();

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors + mon_errors, checks + mon_checks);
        $finish;
    end

endmodule
